// File: rtl/led_seq_pkg.sv
// Shared register map, bit indices and FSM state type for led_sequencer.
// Optional irq support is selected with LED_SEQ_IRQ_EN.
package led_seq_pkg;

  localparam logic [4:0] REG_CTRL    = 5'd0;
  localparam logic [4:0] REG_STATUS  = 5'd1;
  localparam logic [4:0] REG_PERIOD  = 5'd2;
  localparam logic [4:0] REG_LENGTH  = 5'd3;
  localparam logic [4:0] REG_PATTERN = 5'd16;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    WAIT,
    NEXT
  } led_seq_state_t;

endpackage

// File: rtl/led_seq_timer.sv
// Loadable 32-bit down-counter; expire is high while the count is 1.
// A load of 0 is treated as 1 so every step lasts at least one cycle.
module led_seq_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        dec,
  input  logic [31:0] value,
  output logic        expire
);

  logic [31:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (value == 32'd0) ? 32'd1 : value;
    end else if (dec && cnt != 32'd0) begin
      cnt <= cnt - 32'd1;
    end
  end

  assign expire = (cnt == 32'd1);

endmodule

// File: rtl/led_sequencer.sv
// Avalon-MM LED pattern player: config slave avs_s0, LED master avm_m0.
// Define LED_SEQ_IRQ_EN to add the irq output and CTRL[2] IRQ_EN.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_STEPS    = 8,
  parameter int LED_W        = 8,
  parameter int M_ADDR_W     = 1,
  parameter int LED_REG_ADDR = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          avs_s0_address,
  input  logic                avs_s0_read,
  input  logic                avs_s0_write,
  output logic [31:0]         avs_s0_readdata,
  input  logic [31:0]         avs_s0_writedata,
  output logic [M_ADDR_W-1:0] avm_m0_address,
  output logic                avm_m0_write,
  output logic [31:0]         avm_m0_writedata,
  input  logic                avm_m0_waitrequest
`ifdef LED_SEQ_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int STEP_W = $clog2(NUM_STEPS);

  led_seq_state_t   state, state_n;
  logic [STEP_W-1:0] step, step_n;
  logic [LED_W-1:0]  pattern [NUM_STEPS];
  logic [LED_W-1:0]  wdata;
  logic [31:0]       period, length, len_eff;
  logic              en, oneshot, irq_en, done;
  logic              done_set, en_clr, fetch;
  logic              tmr_load, tmr_dec, expire, last;
  logic              pat_hit, sts_w1c;
  logic [STEP_W-1:0] pidx;

  assign pat_hit = avs_s0_address[4] &&
                   ({28'b0, avs_s0_address[3:0]} < 32'(NUM_STEPS));
  assign pidx    = avs_s0_address[STEP_W-1:0];
  assign sts_w1c = avs_s0_write && avs_s0_address == REG_STATUS &&
                   avs_s0_writedata[STAT_DONE];

  always_comb begin
    if (length == 32'd0) len_eff = 32'd1;
    else if (length > 32'(NUM_STEPS)) len_eff = 32'(NUM_STEPS);
    else len_eff = length;
  end

  assign last = (32'(step) == len_eff - 32'd1);

  led_seq_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .dec    (tmr_dec),
    .value  (period),
    .expire (expire)
  );

  always_comb begin
    state_n  = state;
    step_n   = step;
    done_set = 1'b0;
    en_clr   = 1'b0;
    fetch    = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = WRITE;
          step_n  = '0;
          fetch   = 1'b1;
        end
      end
      WRITE: begin
        // the in-flight write always completes, even if EN was cleared
        if (!avm_m0_waitrequest) begin
          if (en) begin
            state_n  = WAIT;
            tmr_load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      WAIT: begin
        if (!en) begin
          state_n = IDLE;
        end else begin
          tmr_dec = 1'b1;
          if (expire) state_n = NEXT;
        end
      end
      NEXT: begin
        if (last) begin
          done_set = 1'b1;
          if (oneshot) begin
            en_clr  = 1'b1;
            state_n = IDLE;
          end else begin
            step_n  = '0;
            state_n = WRITE;
            fetch   = 1'b1;
          end
        end else begin
          step_n  = step + 1'b1;
          state_n = WRITE;
          fetch   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
      wdata <= '0;
    end else begin
      state <= state_n;
      step  <= step_n;
      if (fetch) wdata <= pattern[step_n];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en      <= 1'b0;
      oneshot <= 1'b0;
      done    <= 1'b0;
      period  <= '0;
      length  <= '0;
      for (int i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else begin
      if (avs_s0_write) begin
        unique case (1'b1)
          avs_s0_address == REG_CTRL: begin
            en      <= avs_s0_writedata[CTRL_EN];
            oneshot <= avs_s0_writedata[CTRL_ONESHOT];
          end
          avs_s0_address == REG_PERIOD: period <= avs_s0_writedata;
          avs_s0_address == REG_LENGTH: length <= avs_s0_writedata;
          pat_hit: pattern[pidx] <= avs_s0_writedata[LED_W-1:0];
          default: ;
        endcase
      end
      if (en_clr) en <= 1'b0;
      if (done_set) done <= 1'b1;
      else if (sts_w1c) done <= 1'b0;
    end
  end

`ifdef LED_SEQ_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (avs_s0_write && avs_s0_address == REG_CTRL)
        irq_en <= avs_s0_writedata[CTRL_IRQ_EN];
      irq <= done & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    avs_s0_readdata = '0;
    if (avs_s0_read) begin
      unique case (1'b1)
        avs_s0_address == REG_CTRL:
          avs_s0_readdata = {29'b0, irq_en, oneshot, en};
        avs_s0_address == REG_STATUS:
          avs_s0_readdata = {24'b0, 4'(step), 2'b0, done,
                             state != IDLE};
        avs_s0_address == REG_PERIOD: avs_s0_readdata = period;
        avs_s0_address == REG_LENGTH: avs_s0_readdata = length;
        pat_hit: avs_s0_readdata = 32'(pattern[pidx]);
        default: avs_s0_readdata = '0;
      endcase
    end
  end

  assign avm_m0_address   = M_ADDR_W'(LED_REG_ADDR);
  assign avm_m0_write     = (state == WRITE);
  assign avm_m0_writedata = 32'(wdata);

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with a scoreboard of expected
// LED writes (data and spacing) checked by a bus monitor.
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  address;
  logic        read, write;
  logic [31:0] readdata, writedata;
  logic [0:0]  avm_m0_address;
  logic        avm_m0_write;
  logic [31:0] avm_m0_writedata;
  logic        wreq;
`ifdef LED_SEQ_IRQ_EN
  logic        irq;
`endif

  typedef struct {
    logic [31:0] data;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_acc = 0;
  int lat_cyc = 0;
  bit lat_arm = 0;
  int hold_cnt = 0;
  int last_hold = 0;
  logic [31:0] hold_data = '0;
  logic [31:0] v;
  int ctrl_cyc;

  led_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .avs_s0_address     (address),
    .avs_s0_read        (read),
    .avs_s0_write       (write),
    .avs_s0_readdata    (readdata),
    .avs_s0_writedata   (writedata),
    .avm_m0_address     (avm_m0_address),
    .avm_m0_write       (avm_m0_write),
    .avm_m0_writedata   (avm_m0_writedata),
    .avm_m0_waitrequest (wreq)
`ifdef LED_SEQ_IRQ_EN
    ,
    .irq                (irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      hold_cnt = 0;
    end else if (avm_m0_write) begin
      hold_cnt++;
      if (hold_cnt == 1) hold_data = avm_m0_writedata;
      else chk("hold_data", avm_m0_writedata, hold_data);
      if (!wreq) begin
        exp_t e;
        last_hold = hold_cnt;
        hold_cnt = 0;
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL extra_write: observed %0h expected none",
                 avm_m0_writedata);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wdata", avm_m0_writedata, e.data);
          if (e.gap != 0) chk("gap", 32'(cyc - prev_acc), 32'(e.gap));
        end
        chk("m_addr", 32'(avm_m0_address), 32'd0);
        prev_acc = cyc;
        if (lat_arm) begin
          lat_cyc = cyc;
          lat_arm = 0;
        end
      end
    end else begin
      hold_cnt = 0;
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a; read = 1'b1;
    #3 d = readdata;
    read = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input int g);
    exp_t e;
    e.data = d;
    e.gap = g;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_size(input int n, input int budget);
    for (int i = 0; i < budget && sb.size() > n; i++) @(posedge clk);
    chk("wait_size", 32'(sb.size()), 32'(n));
  endtask

  task automatic wait_write(input int budget);
    @(negedge clk);
    for (int i = 0; i < budget && !avm_m0_write; i++) @(negedge clk);
    chk("write_seen", {31'b0, avm_m0_write}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    address = '0; read = 0; write = 0; writedata = '0; wreq = 0;
    idle(3);
    reset = 1'b0;

    rd_chk("rst_ctrl", 5'd0, 32'h0);
    rd_chk("rst_status", 5'd1, 32'h0);
    rd_chk("rst_period", 5'd2, 32'h0);
    rd_chk("rst_length", 5'd3, 32'h0);
    chk("rst_mwrite", {31'b0, avm_m0_write}, 32'd0);

    // loop playback, 6-cycle spacing
    wr(5'd16, 32'h01); wr(5'd17, 32'h02); wr(5'd18, 32'h04);
    wr(5'd3, 32'd3); wr(5'd2, 32'd4);
    rd_chk("pat1_rb", 5'd17, 32'h02);
    push(32'h01, 0); push(32'h02, 6); push(32'h04, 6);
    push(32'h01, 6); push(32'h02, 6);
    lat_arm = 1;
    wr(5'd0, 32'd1);
    ctrl_cyc = cyc;
    drain("loop_drain", 100);
    chk("latency", 32'(lat_cyc - ctrl_cyc), 32'd1);
    wr(5'd0, 32'd0);
    idle(10);

    // oneshot
    wr(5'd1, 32'd2);
    push(32'h01, 0); push(32'h02, 6); push(32'h04, 6);
    wr(5'd0, 32'd3);
    drain("oneshot_drain", 100);
    idle(10);
    rd_chk("oneshot_status", 5'd1, 32'h22);
    rd_chk("oneshot_ctrl", 5'd0, 32'h2);
`ifdef LED_SEQ_IRQ_EN
    wr(5'd0, 32'd6);
    idle(2);
    chk("irq_set", {31'b0, irq}, 32'd1);
`endif
    wr(5'd1, 32'd2);
    idle(2);
    rd_chk("w1c_status", 5'd1, 32'h20);
`ifdef LED_SEQ_IRQ_EN
    chk("irq_clr", {31'b0, irq}, 32'd0);
    wr(5'd0, 32'd0);
`endif

    // backpressure on step 1
    push(32'h01, 0); push(32'h02, 11); push(32'h04, 6);
    wr(5'd0, 32'd1);
    wait_size(2, 50);
    @(posedge clk); #1 wreq = 1'b1;
    wait_write(20);
    repeat (5) @(posedge clk);
    #1 wreq = 1'b0;
    @(negedge clk); #1;
    chk("hold_len", 32'(last_hold), 32'd6);
    drain("bp_drain", 50);
    wr(5'd0, 32'd0);
    idle(10);

    // disable while the write is stalled
    wr(5'd1, 32'd2);
    wreq = 1'b1;
    push(32'h01, 0);
    wr(5'd0, 32'd1);
    wait_write(20);
    wr(5'd0, 32'd0);
    idle(3);
    chk("dis_held", {31'b0, avm_m0_write}, 32'd1);
    @(posedge clk); #1 wreq = 1'b0;
    drain("dis_drain", 10);
    idle(15);
    rd(5'd1, v);
    chk("dis_busy", v & 32'h1, 32'd0);

    // PERIOD=0, LENGTH=0: one step every 3 cycles
    wr(5'd2, 32'd0); wr(5'd3, 32'd0);
    push(32'h01, 0); push(32'h01, 3); push(32'h01, 3); push(32'h01, 3);
    wr(5'd0, 32'd1);
    wait_size(1, 50);
    wr(5'd0, 32'd0);
    drain("min_drain", 20);
    idle(10);
    rd_chk("period0_rb", 5'd2, 32'd0);

    // LENGTH=20 clamps to 8 steps
    wr(5'd19, 32'h08); wr(5'd20, 32'h10); wr(5'd21, 32'h20);
    wr(5'd22, 32'h40); wr(5'd23, 32'h80);
    wr(5'd3, 32'd20); wr(5'd2, 32'd1);
    for (int i = 0; i < 8; i++) push(32'h1 << i, (i == 0) ? 0 : 3);
    wr(5'd0, 32'd3);
    drain("clamp_drain", 100);
    idle(10);
    rd_chk("clamp_length", 5'd3, 32'd20);
    rd_chk("clamp_status", 5'd1, 32'h72);

    wr(5'd5, 32'hdead_beef);
    rd_chk("unmapped", 5'd5, 32'h0);
    rd_chk("pat_oob", 5'd24, 32'h0);

    // async reset mid-write
    wreq = 1'b1;
    wr(5'd0, 32'd1);
    wait_write(20);
    #2 reset = 1'b1;
    #1 chk("rst_drop", {31'b0, avm_m0_write}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    wreq = 1'b0;
    rd_chk("rst2_ctrl", 5'd0, 32'h0);
    rd_chk("rst2_status", 5'd1, 32'h0);
    rd_chk("rst2_length", 5'd3, 32'h0);
    rd_chk("rst2_pat0", 5'd16, 32'h0);
`ifdef LED_SEQ_IRQ_EN
    chk("rst2_irq", {31'b0, irq}, 32'd0);
`endif
    idle(5);
    chk("rst2_mwrite", {31'b0, avm_m0_write}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
